// File: rtl/range_counter.sv
// range_counter: up/down counter between MIN and MAX with prescaled steps,
// clamped parallel load, saturate-or-wrap bounds, compare match and flags.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   clr      - synchronous active-high reset
//   en       - step request, qualified by the prescaler
//   dir      - step direction, 1 = up, 0 = down
//   load     - parallel load strobe (wins over a step)
//   load_val - value to load, clamped into [MIN, MAX]
//   cmp      - compare value for the match pulse
//   sat_clr  - clears sat_flag
//   count    - current count
//   at_max   - count == MAX
//   at_min   - count == MIN
//   match    - one-cycle pulse when count newly equals cmp
//   wrapped  - one-cycle pulse after a wrap (WRAP = 1)
//   sat_flag - sticky, a step was blocked at a bound (WRAP = 0)
module range_counter #(
    parameter int WIDTH    = 8,
    parameter int MIN      = 0,
    parameter int MAX      = (1 << WIDTH) - 1,
    parameter int WRAP     = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp,
    input  logic             sat_clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             match,
    output logic             wrapped,
    output logic             sat_flag
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
    localparam logic [PW-1:0]    DIV_LAST = PW'(PRESCALE - 1);

    // Power-up values equal the clr values.
    logic [WIDTH-1:0] cnt_q     = MIN_V;
    logic [PW-1:0]    div_q     = '0;
    logic             match_q   = 1'b0;
    logic             wrapped_q = 1'b0;
    logic             sat_q     = 1'b0;

    logic [WIDTH-1:0] cnt_n;
    logic [WIDTH-1:0] clamped;
    logic [PW-1:0]    div_n;
    logic             step;
    logic             upd;
    logic             wrap_ev;
    logic             blocked;

    // >= and <= keep the clamp free of constant compares at full-range bounds.
    always_comb begin
        clamped = load_val;
        if (load_val >= MAX_V) begin
            clamped = MAX_V;
        end else if (load_val <= MIN_V) begin
            clamped = MIN_V;
        end
    end

    always_comb begin
        cnt_n   = cnt_q;
        div_n   = div_q;
        step    = 1'b0;
        upd     = 1'b0;
        wrap_ev = 1'b0;
        blocked = 1'b0;

        if (load) begin
            cnt_n = clamped;
            div_n = '0;
            upd   = 1'b1;
        end else if (en) begin
            if (div_q == DIV_LAST) begin
                div_n = '0;
                step  = 1'b1;
            end else begin
                div_n = div_q + 1'b1;
            end
        end

        // Bounds are compared before the +/-1 so nothing can overflow.
        if (step) begin
            upd = 1'b1;
            if (dir) begin
                if (cnt_q < MAX_V) begin
                    cnt_n = cnt_q + 1'b1;
                end else if (WRAP != 0) begin
                    cnt_n   = MIN_V;
                    wrap_ev = 1'b1;
                end else begin
                    blocked = 1'b1;
                end
            end else begin
                if (cnt_q > MIN_V) begin
                    cnt_n = cnt_q - 1'b1;
                end else if (WRAP != 0) begin
                    cnt_n   = MAX_V;
                    wrap_ev = 1'b1;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q     <= MIN_V;
            div_q     <= '0;
            match_q   <= 1'b0;
            wrapped_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_n;
            div_q     <= div_n;
            // Only a change onto cmp pulses; a held value never re-pulses.
            match_q   <= upd && (cnt_n == cmp) && (cnt_q != cmp);
            wrapped_q <= wrap_ev;
            // A blocked step outranks a same-cycle clear.
            if (blocked) begin
                sat_q <= 1'b1;
            end else if (sat_clr) begin
                sat_q <= 1'b0;
            end
        end
    end

    assign count    = cnt_q;
    assign at_max   = (cnt_q == MAX_V);
    assign at_min   = (cnt_q == MIN_V);
    assign match    = match_q;
    assign wrapped  = wrapped_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_range_counter.sv
// tb_range_counter: drives three range_counter configurations with shared
// directed and random stimulus against an integer reference model.
module tb_range_counter;

    logic       clk = 1'b0;
    logic       clr;
    logic       en;
    logic       dir;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] cmp;
    logic       sat_clr;

    logic [7:0] cnt [3];
    logic       amax [3];
    logic       amin [3];
    logic       mt [3];
    logic       wr [3];
    logic       sf [3];

    int mins [3] = '{0, 3, 5};
    int maxs [3] = '{255, 10, 100};
    int wraps [3] = '{0, 1, 0};
    int pres [3] = '{1, 1, 4};

    int m_cnt [3];
    int m_div [3];
    int m_sat [3];
    int m_match [3];
    int m_wrap [3];

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    always #5 clk = ~clk;

    range_counter #(.WIDTH(8)) u0 (
        .clk(clk), .clr(clr), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .cmp(cmp), .sat_clr(sat_clr),
        .count(cnt[0]), .at_max(amax[0]), .at_min(amin[0]),
        .match(mt[0]), .wrapped(wr[0]), .sat_flag(sf[0])
    );

    range_counter #(.WIDTH(8), .MIN(3), .MAX(10), .WRAP(1)) u1 (
        .clk(clk), .clr(clr), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .cmp(cmp), .sat_clr(sat_clr),
        .count(cnt[1]), .at_max(amax[1]), .at_min(amin[1]),
        .match(mt[1]), .wrapped(wr[1]), .sat_flag(sf[1])
    );

    range_counter #(.WIDTH(8), .MIN(5), .MAX(100), .PRESCALE(4)) u2 (
        .clk(clk), .clr(clr), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .cmp(cmp), .sat_clr(sat_clr),
        .count(cnt[2]), .at_max(amax[2]), .at_min(amin[2]),
        .match(mt[2]), .wrapped(wr[2]), .sat_flag(sf[2])
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d",
                     tag, cycle, got, exp);
        end
    endtask

    // Reference: counts live in [MIN, MAX]; wrap is modular arithmetic
    // over a span of MAX-MIN+1 values offset by MIN.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int old;
            int span;
            int upd;
            old = m_cnt[k];
            span = maxs[k] - mins[k] + 1;
            upd = 0;
            m_match[k] = 0;
            m_wrap[k] = 0;
            if (clr) begin
                m_cnt[k] = mins[k];
                m_div[k] = 0;
                m_sat[k] = 0;
                continue;
            end
            if (sat_clr) m_sat[k] = 0;
            if (load) begin
                if (int'(load_val) > maxs[k]) m_cnt[k] = maxs[k];
                else if (int'(load_val) < mins[k]) m_cnt[k] = mins[k];
                else m_cnt[k] = int'(load_val);
                m_div[k] = 0;
                upd = 1;
            end else if (en) begin
                m_div[k] = m_div[k] + 1;
                if (m_div[k] == pres[k]) begin
                    m_div[k] = 0;
                    upd = 1;
                    if (dir) begin
                        if (old == maxs[k] && wraps[k] == 0) begin
                            m_sat[k] = 1;
                        end else begin
                            m_cnt[k] = mins[k] + (old - mins[k] + 1) % span;
                            m_wrap[k] = (old == maxs[k]) ? 1 : 0;
                        end
                    end else begin
                        if (old == mins[k] && wraps[k] == 0) begin
                            m_sat[k] = 1;
                        end else begin
                            m_cnt[k] = mins[k] + (old - mins[k] - 1 + span) % span;
                            m_wrap[k] = (old == mins[k]) ? 1 : 0;
                        end
                    end
                end
            end
            if (upd != 0 && m_cnt[k] == int'(cmp) && old != int'(cmp))
                m_match[k] = 1;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("d%0d_count", k), int'(cnt[k]), m_cnt[k]);
            check($sformatf("d%0d_at_max", k), int'(amax[k]),
                  (m_cnt[k] == maxs[k]) ? 1 : 0);
            check($sformatf("d%0d_at_min", k), int'(amin[k]),
                  (m_cnt[k] == mins[k]) ? 1 : 0);
            check($sformatf("d%0d_match", k), int'(mt[k]), m_match[k]);
            check($sformatf("d%0d_wrapped", k), int'(wr[k]), m_wrap[k]);
            check($sformatf("d%0d_sat_flag", k), int'(sf[k]), m_sat[k]);
        end
    endtask

    task automatic cyc(input int c, input int e, input int d, input int l,
                       input int lv, input int cp, input int sc);
        clr = c[0];
        en = e[0];
        dir = d[0];
        load = l[0];
        load_val = lv[7:0];
        cmp = cp[7:0];
        sat_clr = sc[0];
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        cycle++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int tend;
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = mins[k];
            m_div[k] = 0;
            m_sat[k] = 0;
            m_match[k] = 0;
            m_wrap[k] = 0;
        end
        clr = 1'b1;
        en = 1'b0;
        dir = 1'b1;
        load = 1'b0;
        load_val = '0;
        cmp = '0;
        sat_clr = 1'b0;
        #1;

        repeat (2) cyc(1, 0, 1, 0, 0, 5, 0);
        check("reset_count", int'(cnt[0]), 0);
        check("reset_at_min", int'(amin[0]), 1);

        // Climb to the top and saturate, cmp=5 pulses once on the way.
        repeat (300) cyc(0, 1, 1, 0, 0, 5, 0);
        check("climb_top", int'(cnt[0]), 255);
        check("climb_sat", int'(sf[0]), 1);
        repeat (4) cyc(0, 1, 1, 0, 0, 255, 0);
        check("sat_no_rematch", int'(mt[0]), 0);

        cyc(0, 1, 1, 0, 0, 0, 1);
        check("sat_set_wins", int'(sf[0]), 1);
        cyc(0, 0, 1, 0, 0, 0, 1);
        check("sat_clr", int'(sf[0]), 0);
        cyc(0, 1, 1, 0, 0, 0, 0);

        // Load beats a same-cycle step, then step onto 37 and clear.
        cyc(0, 1, 1, 1, 36, 0, 0);
        check("load_wins", int'(cnt[0]), 36);
        cyc(0, 1, 1, 0, 0, 0, 0);
        check("count_37", int'(cnt[0]), 37);
        check("sat_kept_37", int'(sf[0]), 1);
        cyc(1, 1, 1, 0, 0, 0, 0);
        check("clr_mid_count", int'(cnt[0]), 0);
        check("clr_sat", int'(sf[0]), 0);

        // Wrap in both directions on the 3..10 instance.
        cyc(0, 0, 1, 1, 10, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        check("wrap_up", int'(cnt[1]), 3);
        check("wrap_up_pulse", int'(wr[1]), 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("wrap_dn", int'(cnt[1]), 10);
        check("wrap_dn_pulse", int'(wr[1]), 1);

        // Prescale by 4: 12 en cycles give 3 steps, gaps hold the divider.
        cyc(1, 0, 1, 0, 0, 0, 0);
        repeat (12) cyc(0, 1, 1, 0, 0, 7, 0);
        check("presc_3_steps", int'(cnt[2]), 8);
        repeat (2) cyc(0, 1, 1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        check("presc_held", int'(cnt[2]), 8);
        cyc(0, 1, 1, 0, 0, 0, 0);
        check("presc_resume", int'(cnt[2]), 9);

        // Clamped loads; a load mid-period restarts the divider.
        cyc(0, 0, 1, 1, 200, 0, 0);
        check("clamp_hi", int'(cnt[2]), 100);
        cyc(0, 0, 1, 1, 1, 0, 0);
        check("clamp_lo", int'(cnt[2]), 5);
        repeat (2) cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 50, 0, 0);
        repeat (3) cyc(0, 1, 1, 0, 0, 0, 0);
        check("load_zero_div", int'(cnt[2]), 50);
        cyc(0, 1, 1, 0, 0, 0, 0);
        check("load_div_step", int'(cnt[2]), 51);

        // Random traffic with a slowly changing direction bias.
        tend = 80;
        for (int i = 0; i < 3000; i++) begin
            int c;
            int e;
            int d;
            int l;
            int lv;
            int cp;
            int sc;
            if (i % 64 == 0) tend = int'($urandom_range(10, 90));
            c = ($urandom_range(0, 127) == 0) ? 1 : 0;
            e = ($urandom_range(0, 3) != 0) ? 1 : 0;
            d = (int'($urandom_range(0, 99)) < tend) ? 1 : 0;
            l = ($urandom_range(0, 11) == 0) ? 1 : 0;
            lv = int'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0: cp = int'($urandom_range(0, 255));
                1: cp = int'($urandom_range(0, 12));
                2: cp = int'($urandom_range(95, 105));
                default: cp = 255;
            endcase
            sc = ($urandom_range(0, 15) == 0) ? 1 : 0;
            cyc(c, e, d, l, lv, cp, sc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
